seg_scan_display: RTL

//  Downstream consumer of the 32-bit display word built from the count/setting values.
//  The word is packed as hi*10000+lo and holds at most 99,999,999.

---
 rtl/seg_scan_display.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - binary-to-BCD double-dabble converter driving a scanned 8-digit 7-segment display
module seg_scan_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] data_in,
  output logic [7:0]  dig_sel,
  output logic [7:0]  seg,
  output logic        busy,
  output logic        ovf
);

  localparam int            CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_MAX = CW'(SCAN_DIV - 1);
  localparam logic [31:0]   MAX_DISP = 32'd99_999_999;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   last_val_q, last_val_d;
  logic [31:0]   src_q, src_d;
  logic [31:0]   bcd_acc_q, bcd_acc_d;
  logic [4:0]    iter_q, iter_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   bcd_reg_q, bcd_reg_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    dig_idx_q, dig_idx_d;
  logic [7:0]    dig_sel_q, dig_sel_d;
  logic [7:0]    seg_q, seg_d;
  logic [31:0]   acc_adj;

  function automatic logic [31:0] dabble_adjust(input logic [31:0] acc);
    logic [31:0] r;
    r = acc;
    for (int i = 0; i < 8; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'h3F;
      4'd1:    return 8'h06;
      4'd2:    return 8'h5B;
      4'd3:    return 8'h4F;
      4'd4:    return 8'h66;
      4'd5:    return 8'h6D;
      4'd6:    return 8'h7D;
      4'd7:    return 8'h07;
      4'd8:    return 8'h7F;
      4'd9:    return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  assign acc_adj = dabble_adjust(bcd_acc_q);

  always_comb begin
    state_d    = state_q;
    last_val_d = last_val_q;
    src_d      = src_q;
    bcd_acc_d  = bcd_acc_q;
    iter_d     = iter_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    bcd_reg_d  = bcd_reg_q;
    case (state_q)
      IDLE: begin
        if (data_in != last_val_q) begin
          src_d      = data_in;
          last_val_d = data_in;
          bcd_acc_d  = '0;
          iter_d     = '0;
          busy_d     = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        // Adjust-then-shift; bits shifted out of the top nibble are dropped.
        {bcd_acc_d, src_d} = {acc_adj, src_q} << 1;
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        busy_d = 1'b0;
        if (last_val_q > MAX_DISP) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d     = 1'b0;
          bcd_reg_d = bcd_acc_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    dig_idx_d  = dig_idx_q;
    if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_d = '0;
      dig_idx_d  = dig_idx_q + 3'd1;
    end
    // Outputs are registered so segment and digit lines switch together.
    dig_sel_d = 8'b1 << dig_idx_q;
    seg_d     = ovf_q ? 8'h40 : seg_decode(bcd_reg_q[4*dig_idx_q +: 4]);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      last_val_q <= '0;
      src_q      <= '0;
      bcd_acc_q  <= '0;
      iter_q     <= '0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_reg_q  <= '0;
      scan_cnt_q <= '0;
      dig_idx_q  <= '0;
      dig_sel_q  <= 8'h01;
      seg_q      <= 8'h3F;
    end else begin
      state_q    <= state_d;
      last_val_q <= last_val_d;
      src_q      <= src_d;
      bcd_acc_q  <= bcd_acc_d;
      iter_q     <= iter_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      bcd_reg_q  <= bcd_reg_d;
      scan_cnt_q <= scan_cnt_d;
      dig_idx_q  <= dig_idx_d;
      dig_sel_q  <= dig_sel_d;
      seg_q      <= seg_d;
    end
  end

  assign dig_sel = dig_sel_q;
  assign seg     = seg_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;

endmodule
